dt_pass_sched: RTL and testbench

Pass scheduler for the distance-transform datapath. It sequences one complete transform of a binary image: a forward raster pass over interior pixels, a drain, then a backward raster pass. For each row it requests a line-buffer load, then issues pixel coordinates to the per-pixel min/+1 engine over a valid/ready handshake. It sits between the top-level start/done control and the DT engine, and owns all ordering and pass-boundary decisions.

---
 rtl/dt_pkg.sv | 25 ++
 rtl/dt_raster_cnt.sv | 42 ++++
 rtl/dt_pass_sched.sv | 199 +++++++++++++++++++
 tb/tb_dt_pass_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared types and constants for the distance-transform pass scheduler.
package dt_pkg;

  localparam int unsigned DT_IMG_W = 128;
  localparam int unsigned DT_IMG_H = 128;

  // Width of the untouched image border; interior spans BORDER .. dim-1-BORDER.
  localparam int unsigned DT_BORDER = 1;

  typedef enum logic [2:0] {
    StIdle,
    StFLoad,
    StFIssue,
    StDrain,
    StBLoad,
    StBIssue,
    StFin
  } dt_sched_state_t;

  typedef enum logic {
    DT_FWD = 1'b0,
    DT_BWD = 1'b1
  } dt_pass_t;

endpackage

// File: rtl/dt_raster_cnt.sv
// Loadable up/down coordinate counter that stops at a caller-supplied terminal
// value; the next-state value is exported so the caller can register outputs.
module dt_raster_cnt #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         down,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] val,
  output logic [W-1:0] nxt,
  output logic         at_term
);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_term = (cnt_q == term_val);
  assign val     = cnt_q;
  assign nxt     = cnt_d;

  // Stepping is suppressed at the terminal value so the count can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (step && !at_term) begin
      cnt_d = down ? (cnt_q - W'(1)) : (cnt_q + W'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dt_pass_sched.sv
// Sequences forward raster pass, drain and backward raster pass of one distance
// transform; every output is a flop loaded from next-state values.
module dt_pass_sched
  import dt_pkg::*;
#(
  parameter int unsigned IMG_W = DT_IMG_W,
  parameter int unsigned IMG_H = DT_IMG_H,
  parameter int unsigned CW    = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          ln_req,
  output logic [CW-1:0] ln_row,
  input  logic          ln_ack,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_pass,
  output logic [CW-1:0] pix_row,
  output logic [CW-1:0] pix_col,
  output logic          pix_last,
  input  logic          eng_idle
);

  localparam logic [CW-1:0] Lo    = CW'(DT_BORDER);
  localparam logic [CW-1:0] ColHi = CW'(IMG_W - 1 - DT_BORDER);
  localparam logic [CW-1:0] RowHi = CW'(IMG_H - 1 - DT_BORDER);

  dt_sched_state_t state_q, state_d;

  logic          bwd_cur;
  logic          row_load, row_step, row_term;
  logic          col_load, col_step, col_term;
  logic [CW-1:0] row_load_val, col_load_val;
  logic [CW-1:0] row_val, row_nxt, col_val, col_nxt;
  logic [CW-1:0] row_term_val, col_term_val;

  logic          busy_d, done_d, req_d, valid_d, last_d;
  dt_pass_t      pass_d;

  assign bwd_cur      = (state_q == StBLoad) || (state_q == StBIssue);
  assign row_term_val = bwd_cur ? Lo : RowHi;
  assign col_term_val = bwd_cur ? Lo : ColHi;

  dt_raster_cnt #(
    .W (CW)
  ) u_row_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (row_load),
    .load_val (row_load_val),
    .step     (row_step),
    .down     (bwd_cur),
    .term_val (row_term_val),
    .val      (row_val),
    .nxt      (row_nxt),
    .at_term  (row_term)
  );

  dt_raster_cnt #(
    .W (CW)
  ) u_col_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (col_load),
    .load_val (col_load_val),
    .step     (col_step),
    .down     (bwd_cur),
    .term_val (col_term_val),
    .val      (col_val),
    .nxt      (col_nxt),
    .at_term  (col_term)
  );

  always_comb begin
    state_d      = state_q;
    row_load     = 1'b0;
    row_load_val = Lo;
    row_step     = 1'b0;
    col_load     = 1'b0;
    col_load_val = Lo;
    col_step     = 1'b0;

    unique case (state_q)
      StIdle, StFin: begin
        if (start) begin
          state_d      = StFLoad;
          row_load     = 1'b1;
          row_load_val = Lo;
        end
      end
      StFLoad: begin
        if (ln_ack) begin
          state_d      = StFIssue;
          col_load     = 1'b1;
          col_load_val = Lo;
        end
      end
      // pix_valid is high throughout the issue states, so pix_ready alone marks a transfer.
      StFIssue: begin
        if (pix_ready) begin
          if (!col_term) begin
            col_step = 1'b1;
          end else if (row_term) begin
            state_d = StDrain;
          end else begin
            row_step = 1'b1;
            state_d  = StFLoad;
          end
        end
      end
      StDrain: begin
        if (eng_idle) begin
          state_d      = StBLoad;
          row_load     = 1'b1;
          row_load_val = RowHi;
        end
      end
      StBLoad: begin
        if (ln_ack) begin
          state_d      = StBIssue;
          col_load     = 1'b1;
          col_load_val = ColHi;
        end
      end
      StBIssue: begin
        if (pix_ready) begin
          if (!col_term) begin
            col_step = 1'b1;
          end else if (row_term) begin
            state_d = StFin;
          end else begin
            row_step = 1'b1;
            state_d  = StBLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d  = StIdle;
      row_load = 1'b0;
      row_step = 1'b0;
      col_load = 1'b0;
      col_step = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode works on next-state values so the ports come straight from flops.
  always_comb begin
    busy_d  = state_d inside {StFLoad, StFIssue, StDrain, StBLoad, StBIssue};
    done_d  = (state_d == StFin);
    req_d   = (state_d == StFLoad) || (state_d == StBLoad);
    valid_d = (state_d == StFIssue) || (state_d == StBIssue);
    pass_d  = (state_d == StBIssue) ? DT_BWD : DT_FWD;
    last_d  = 1'b0;
    if (valid_d) begin
      last_d = (pass_d == DT_BWD) ? ((row_nxt == Lo) && (col_nxt == Lo))
                                  : ((row_nxt == RowHi) && (col_nxt == ColHi));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      ln_req    <= 1'b0;
      ln_row    <= '0;
      pix_valid <= 1'b0;
      pix_pass  <= 1'b0;
      pix_row   <= '0;
      pix_col   <= '0;
      pix_last  <= 1'b0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      ln_req    <= req_d;
      ln_row    <= req_d ? row_nxt : '0;
      pix_valid <= valid_d;
      pix_pass  <= pass_d;
      pix_row   <= valid_d ? row_nxt : '0;
      pix_col   <= valid_d ? col_nxt : '0;
      pix_last  <= last_d;
    end
  end

endmodule

// File: tb/tb_dt_pass_sched.sv
// Bench for dt_pass_sched: a 4x4 instance driven from a cycle table plus corner
// sequences, and a default 128x128 instance run with random stalls.
module tb_dt_pass_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4x4 instance
  logic       s_reset, s_start, s_abort, s_ln_ack, s_ready, s_eng_idle;
  logic       s_busy, s_done, s_ln_req, s_pix_valid, s_pix_pass, s_pix_last;
  logic [1:0] s_ln_row, s_pix_row, s_pix_col;
  logic [11:0] s_obs;

  // 128x128 instance
  logic       b_reset, b_start, b_abort, b_ln_ack, b_ready, b_eng_idle;
  logic       b_busy, b_done, b_ln_req, b_pix_valid, b_pix_pass, b_pix_last;
  logic [6:0] b_ln_row, b_pix_row, b_pix_col;
  logic [26:0] b_obs;

  assign s_obs = {s_busy, s_done, s_ln_req, s_ln_row, s_pix_valid, s_pix_pass,
                  s_pix_row, s_pix_col, s_pix_last};
  assign b_obs = {b_busy, b_done, b_ln_req, b_ln_row, b_pix_valid, b_pix_pass,
                  b_pix_row, b_pix_col, b_pix_last};

  dt_pass_sched #(
    .IMG_W (4),
    .IMG_H (4)
  ) u_small (
    .clk       (clk),
    .reset     (s_reset),
    .start     (s_start),
    .abort     (s_abort),
    .busy      (s_busy),
    .done      (s_done),
    .ln_req    (s_ln_req),
    .ln_row    (s_ln_row),
    .ln_ack    (s_ln_ack),
    .pix_valid (s_pix_valid),
    .pix_ready (s_ready),
    .pix_pass  (s_pix_pass),
    .pix_row   (s_pix_row),
    .pix_col   (s_pix_col),
    .pix_last  (s_pix_last),
    .eng_idle  (s_eng_idle)
  );

  dt_pass_sched u_big (
    .clk       (clk),
    .reset     (b_reset),
    .start     (b_start),
    .abort     (b_abort),
    .busy      (b_busy),
    .done      (b_done),
    .ln_req    (b_ln_req),
    .ln_row    (b_ln_row),
    .ln_ack    (b_ln_ack),
    .pix_valid (b_pix_valid),
    .pix_ready (b_ready),
    .pix_pass  (b_pix_pass),
    .pix_row   (b_pix_row),
    .pix_col   (b_pix_col),
    .pix_last  (b_pix_last),
    .eng_idle  (b_eng_idle)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Field order of expected words: busy done ln_req ln_row v pass row col last
  typedef struct packed {
    logic        start;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [15];

  int n_xfer [2];
  int n_load [2];
  int exp_pass, exp_row, exp_col, drain_cnt;
  bit exp_last, fwd_done, bwd_load_seen, finished;
  bit found;

  initial begin
    vecs[0]  = '{start: 1'b1, exp: 12'b1_0_1_01_0_0_00_00_0};
    vecs[1]  = '{start: 1'b0, exp: 12'b1_0_0_00_1_0_01_01_0};
    vecs[2]  = '{start: 1'b0, exp: 12'b1_0_0_00_1_0_01_10_0};
    vecs[3]  = '{start: 1'b0, exp: 12'b1_0_1_10_0_0_00_00_0};
    vecs[4]  = '{start: 1'b0, exp: 12'b1_0_0_00_1_0_10_01_0};
    vecs[5]  = '{start: 1'b0, exp: 12'b1_0_0_00_1_0_10_10_1};
    vecs[6]  = '{start: 1'b0, exp: 12'b1_0_0_00_0_0_00_00_0};
    vecs[7]  = '{start: 1'b0, exp: 12'b1_0_1_10_0_0_00_00_0};
    vecs[8]  = '{start: 1'b0, exp: 12'b1_0_0_00_1_1_10_10_0};
    vecs[9]  = '{start: 1'b0, exp: 12'b1_0_0_00_1_1_10_01_0};
    vecs[10] = '{start: 1'b0, exp: 12'b1_0_1_01_0_0_00_00_0};
    vecs[11] = '{start: 1'b0, exp: 12'b1_0_0_00_1_1_01_10_0};
    vecs[12] = '{start: 1'b0, exp: 12'b1_0_0_00_1_1_01_01_1};
    vecs[13] = '{start: 1'b0, exp: 12'b0_1_0_00_0_0_00_00_0};
    vecs[14] = '{start: 1'b0, exp: 12'b0_1_0_00_0_0_00_00_0};

    s_reset = 1'b1; s_start = 1'b0; s_abort = 1'b0;
    s_ln_ack = 1'b1; s_ready = 1'b1; s_eng_idle = 1'b1;
    b_reset = 1'b1; b_start = 1'b0; b_abort = 1'b0;
    b_ln_ack = 1'b0; b_ready = 1'b0; b_eng_idle = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_state_small", 32'(s_obs), 32'd0);
    chk("reset_state_big", 32'(b_obs), 32'd0);
    s_reset = 1'b0;
    b_reset = 1'b0;
    @(negedge clk);

    // ---- 4x4 full run, ready/ack held high ----
    for (int i = 0; i < 15; i++) begin
      s_start = vecs[i].start;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(s_obs), 32'(vecs[i].exp));
    end
    s_start = 1'b0;

    // start in FIN clears done and reloads row 1
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("start_in_fin", 32'(s_obs), 32'(12'b1_0_1_01_0_0_00_00_0));

    // start during backward issue is ignored
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (s_pix_valid && s_pix_pass) found = 1'b1;
      else @(negedge clk);
    end
    chk("reach_bissue", 32'(found), 32'd1);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("start_in_bissue", 32'(s_obs), 32'(12'b1_0_0_00_1_1_10_01_0));
    for (int k = 0; k < 20 && !s_done; k++) @(negedge clk);
    chk("done_after_bissue", 32'({s_done, s_busy}), 32'(2'b10));

    // asynchronous reset mid-run
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (3) @(negedge clk);
    #2 s_reset = 1'b1;
    #1 chk("async_reset", 32'(s_obs), 32'd0);
    @(negedge clk);
    s_reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", 32'(s_obs), 32'd0);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("restart_after_reset", 32'(s_obs), 32'(12'b1_0_1_01_0_0_00_00_0));

    // ---- 128x128 run with random stalls and a long drain ----
    n_xfer[0] = 0; n_xfer[1] = 0; n_load[0] = 0; n_load[1] = 0;
    exp_pass = 0; exp_row = 1; exp_col = 1; drain_cnt = 0;
    fwd_done = 1'b0; bwd_load_seen = 1'b0; finished = 1'b0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int cyc = 0; cyc < 60000 && !b_done; cyc++) begin
      b_ready  = ($urandom_range(3) != 0);
      b_ln_ack = ($urandom_range(2) == 0);
      if (fwd_done && !bwd_load_seen) begin
        if (b_ln_req) begin
          bwd_load_seen = 1'b1;
          chk("drain_len", 32'(drain_cnt), 32'd20);
          chk("first_bwd_row", 32'(b_ln_row), 32'd126);
        end else begin
          drain_cnt++;
          chk("drain_hold", 32'({b_busy, b_pix_valid}), 32'(2'b10));
          if (drain_cnt == 20) b_eng_idle = 1'b1;
        end
      end
      if (b_ln_req && b_ln_ack) begin
        chk("ln_row", 32'(b_ln_row), 32'(exp_row));
        n_load[exp_pass]++;
      end
      if (b_pix_valid) begin
        exp_last = (exp_pass == 0) ? (exp_row == 126 && exp_col == 126)
                                   : (exp_row == 1 && exp_col == 1);
        chk("pix", 32'({b_pix_pass, b_pix_row, b_pix_col, b_pix_last}),
            32'({exp_pass[0], exp_row[6:0], exp_col[6:0], exp_last}));
        if (b_ready) begin
          n_xfer[exp_pass]++;
          if (exp_pass == 0) begin
            if (exp_col == 126) begin
              if (exp_row == 126) begin
                fwd_done = 1'b1; exp_pass = 1; exp_row = 126; exp_col = 126;
              end else begin
                exp_row++; exp_col = 1;
              end
            end else begin
              exp_col++;
            end
          end else begin
            if (exp_col == 1) begin
              if (exp_row == 1) finished = 1'b1;
              else begin
                exp_row--; exp_col = 126;
              end
            end else begin
              exp_col--;
            end
          end
        end
      end
      @(negedge clk);
    end
    chk("big_done", 32'({b_done, b_busy}), 32'(2'b10));
    chk("big_finished", 32'(finished), 32'd1);
    chk("fwd_xfers", 32'(n_xfer[0]), 32'd15876);
    chk("bwd_xfers", 32'(n_xfer[1]), 32'd15876);
    chk("fwd_loads", 32'(n_load[0]), 32'd126);
    chk("bwd_loads", 32'(n_load[1]), 32'd126);

    // ---- abort at (5,9) then restart ----
    b_ready = 1'b1; b_ln_ack = 1'b1; b_eng_idle = 1'b1;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (b_pix_valid && b_pix_row == 7'd5 && b_pix_col == 7'd9) found = 1'b1;
      else @(negedge clk);
    end
    chk("reach_5_9", 32'(found), 32'd1);
    b_abort = 1'b1;
    @(negedge clk);
    b_abort = 1'b0;
    chk("abort_zero", 32'(b_obs), 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_stays_idle", 32'(b_obs), 32'd0);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    chk("restart_load", 32'(b_obs), 32'({3'b101, 7'd1, 2'b00, 7'd0, 7'd0, 1'b0}));
    @(negedge clk);
    chk("restart_pix", 32'(b_obs), 32'({3'b100, 7'd0, 2'b10, 7'd1, 7'd1, 1'b0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
